// File: rtl/rmii_rx_framer.sv
// RMII receive framer: validates preamble/SFD, packs dibits into bytes and
// flags the last byte of each frame, with good/bad frame counters.
module rmii_rx_framer #(
    parameter int MIN_PREAMBLE = 28,
    parameter int MIN_BYTES    = 64,
    parameter int MAX_BYTES    = 1522,
    parameter bit LSB_FIRST    = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             crsdv,
    input  logic [1:0]       rxd,
    output logic             axiov,
    output logic [7:0]       axiod,
    output logic             axiolast,
    output logic             axioerr,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);
    localparam int BCNT_W = $clog2(MAX_BYTES + 2);

    typedef enum logic [1:0] {S_DROP, S_IDLE, S_PRE, S_DATA} state_t;

    state_t            r_state;
    logic [4:0]        r_pcnt;
    logic [1:0]        r_didx;
    logic [7:0]        r_shift;
    logic [7:0]        r_held;
    logic              r_held_v;
    logic [BCNT_W-1:0] r_bcnt;

    logic [7:0]        w_shift_nxt;
    logic [BCNT_W-1:0] w_bcnt_inc;
    logic              w_bad_end;

    always_comb begin
        w_shift_nxt = LSB_FIRST ? {rxd, r_shift[7:2]} : {r_shift[5:0], rxd};
        w_bcnt_inc  = r_bcnt + 1'b1;
        w_bad_end   = (r_didx != 2'd0) || (r_bcnt < BCNT_W'(MIN_BYTES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_DROP;
            r_pcnt   <= '0;
            r_didx   <= '0;
            r_shift  <= '0;
            r_held   <= '0;
            r_held_v <= 1'b0;
            r_bcnt   <= '0;
            axiov    <= 1'b0;
            axiod    <= '0;
            axiolast <= 1'b0;
            axioerr  <= 1'b0;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            axiov    <= 1'b0;
            axiolast <= 1'b0;
            axioerr  <= 1'b0;
            unique case (r_state)
                S_DROP: begin
                    if (!crsdv) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (crsdv) begin
                        if (rxd == 2'b01) begin
                            r_state <= S_PRE;
                            r_pcnt  <= 5'd1;
                        end else begin
                            r_state <= S_DROP;
                        end
                    end
                end
                S_PRE: begin
                    if (!crsdv) begin
                        r_state <= S_IDLE;
                    end else if (rxd == 2'b01) begin
                        if (r_pcnt != '1) r_pcnt <= r_pcnt + 1'b1;
                    end else if (rxd == 2'b11 && r_pcnt >= 5'(MIN_PREAMBLE)) begin
                        r_state  <= S_DATA;
                        r_didx   <= '0;
                        r_bcnt   <= '0;
                        r_shift  <= '0;
                        r_held_v <= 1'b0;
                    end else begin
                        r_state <= S_DROP;
                        bad_cnt <= bad_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (!crsdv) begin
                        r_state  <= S_IDLE;
                        r_held_v <= 1'b0;
                        if (r_held_v) begin
                            axiov    <= 1'b1;
                            axiod    <= r_held;
                            axiolast <= 1'b1;
                            axioerr  <= w_bad_end;
                            if (w_bad_end) bad_cnt  <= bad_cnt + 1'b1;
                            else           good_cnt <= good_cnt + 1'b1;
                        end else begin
                            bad_cnt <= bad_cnt + 1'b1;
                        end
                    end else begin
                        r_shift <= w_shift_nxt;
                        r_didx  <= r_didx + 1'b1;
                        if (r_didx == 2'd3) begin
                            r_bcnt <= w_bcnt_inc;
                            // Held byte is always emitted one byte late so last can be tagged.
                            if (w_bcnt_inc == BCNT_W'(MAX_BYTES + 1)) begin
                                r_state  <= S_DROP;
                                r_held_v <= 1'b0;
                                bad_cnt  <= bad_cnt + 1'b1;
                                if (r_held_v) begin
                                    axiov    <= 1'b1;
                                    axiod    <= r_held;
                                    axiolast <= 1'b1;
                                    axioerr  <= 1'b1;
                                end
                            end else begin
                                if (r_held_v) begin
                                    axiov <= 1'b1;
                                    axiod <= r_held;
                                end
                                r_held   <= w_shift_nxt;
                                r_held_v <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= S_DROP;
            endcase
        end
    end
endmodule

// File: tb/tb_rmii_rx_framer.sv
// Scoreboard bench for rmii_rx_framer: LSB-first DUT (default parameters)
// and an MSB-first DUT, each with its own expected-byte queue.
module tb_rmii_rx_framer;
    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        crsdv0 = 1'b1, crsdv1 = 1'b0;
    logic [1:0]  rxd0 = 2'b01, rxd1 = 2'b00;
    logic        axiov0, axiolast0, axioerr0, axiov1, axiolast1, axioerr1;
    logic [7:0]  axiod0, axiod1;
    logic [15:0] good0, bad0, good1, bad1;

    int   checks = 0;
    int   errors = 0;
    int   exp_good0 = 0, exp_bad0 = 0, exp_good1 = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #10 clk = ~clk;

    rmii_rx_framer dut0 (
        .clk(clk), .rst(rst), .crsdv(crsdv0), .rxd(rxd0),
        .axiov(axiov0), .axiod(axiod0), .axiolast(axiolast0), .axioerr(axioerr0),
        .good_cnt(good0), .bad_cnt(bad0)
    );

    rmii_rx_framer #(.LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst(rst), .crsdv(crsdv1), .rxd(rxd1),
        .axiov(axiov1), .axiod(axiod1), .axiolast(axiolast1), .axioerr(axioerr1),
        .good_cnt(good1), .bad_cnt(bad1)
    );

    always @(negedge clk) begin
        if (axiov0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL strobe0_unexpected: got d=%h last=%b err=%b, required no strobe",
                         axiod0, axiolast0, axioerr0);
            end else begin
                e0 = q0.pop_front();
                if ({axiod0, axiolast0, axioerr0} !== {e0.d, e0.last, e0.err}) begin
                    errors++;
                    $display("FAIL strobe0_data: got d=%h last=%b err=%b, required d=%h last=%b err=%b",
                             axiod0, axiolast0, axioerr0, e0.d, e0.last, e0.err);
                end
            end
        end else if (axiolast0 || axioerr0) begin
            checks++;
            errors++;
            $display("FAIL flags0_idle: got last=%b err=%b with axiov=0, required 0 0", axiolast0, axioerr0);
        end
        if (axiov1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL strobe1_unexpected: got d=%h last=%b err=%b, required no strobe",
                         axiod1, axiolast1, axioerr1);
            end else begin
                e1 = q1.pop_front();
                if ({axiod1, axiolast1, axioerr1} !== {e1.d, e1.last, e1.err}) begin
                    errors++;
                    $display("FAIL strobe1_data: got d=%h last=%b err=%b, required d=%h last=%b err=%b",
                             axiod1, axiolast1, axioerr1, e1.d, e1.last, e1.err);
                end
            end
        end else if (axiolast1 || axioerr1) begin
            checks++;
            errors++;
            $display("FAIL flags1_idle: got last=%b err=%b with axiov=0, required 0 0", axiolast1, axioerr1);
        end
    end

    function automatic logic [7:0] pat(input int i, input int seed);
        return 8'(i + seed);
    endfunction

    task automatic drive(input int which, input logic dv, input logic [1:0] d);
        @(negedge clk);
        if (which == 0) begin crsdv0 = dv; rxd0 = d; end
        else            begin crsdv1 = dv; rxd1 = d; end
    endtask

    // Preamble, SFD, nbytes of pattern, extra stray dibits, then carrier drop.
    task automatic send_frame(input int which, input int npre, input int nbytes,
                              input int extra, input int seed);
        logic [7:0] b;
        for (int i = 0; i < npre; i++) drive(which, 1'b1, 2'b01);
        drive(which, 1'b1, 2'b11);
        for (int i = 0; i < nbytes; i++) begin
            b = pat(i, seed);
            for (int k = 0; k < 4; k++)
                drive(which, 1'b1, (which == 0) ? b[2*k +: 2] : b[6-2*k +: 2]);
        end
        for (int i = 0; i < extra; i++) drive(which, 1'b1, 2'b10);
        for (int i = 0; i < 4; i++) drive(which, 1'b0, 2'b00);
    endtask

    task automatic expect_frame(input int which, input int n, input int seed,
                                input logic has_last, input logic err);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d    = pat(i, seed);
            e.last = has_last && (i == n - 1);
            e.err  = err && (i == n - 1);
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({axiov0, axiod0, axiolast0, axioerr0, good0, bad0} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b e=%b good=%0d bad=%0d, required all 0",
                     axiov0, axiod0, axiolast0, axioerr0, good0, bad0);
        end
        rst = 1'b0;
        // Mid-stream after reset: must be ignored until carrier drops.
        for (int i = 0; i < 10; i++) drive(0, 1'b1, 2'b01);
        drive(0, 1'b1, 2'b11);
        for (int i = 0; i < 80; i++) drive(0, 1'b1, 2'(i));
        for (int i = 0; i < 4; i++) drive(0, 1'b0, 2'b00);
        checks++;
        if (bad0 !== 16'(exp_bad0) || good0 !== 16'(exp_good0)) begin
            errors++;
            $display("FAIL reset_stream_counts: got good=%0d bad=%0d, required %0d %0d",
                     good0, bad0, exp_good0, exp_bad0);
        end
        expect_frame(0, 64, 8'h10, 1'b1, 1'b0);
        send_frame(0, 28, 64, 0, 8'h10);
        exp_good0++;
        checks++;
        if (good0 !== 16'(exp_good0) || q0.size() != 0) begin
            errors++;
            $display("FAIL reset_fresh_frame: got good=%0d pending=%0d, required good=%0d pending=0",
                     good0, q0.size(), exp_good0);
        end
    endtask

    task automatic test_good_frame;
        expect_frame(0, 64, 0, 1'b1, 1'b0);
        send_frame(0, 31, 64, 0, 0);
        exp_good0++;
        checks++;
        if (good0 !== 16'(exp_good0) || bad0 !== 16'(exp_bad0) || q0.size() != 0) begin
            errors++;
            $display("FAIL good_frame: got good=%0d bad=%0d pending=%0d, required %0d %0d 0",
                     good0, bad0, q0.size(), exp_good0, exp_bad0);
        end
        expect_frame(1, 64, 0, 1'b1, 1'b0);
        send_frame(1, 31, 64, 0, 0);
        exp_good1++;
        checks++;
        if (good1 !== 16'(exp_good1) || bad1 !== 16'd0 || q1.size() != 0) begin
            errors++;
            $display("FAIL msb_first_frame: got good=%0d bad=%0d pending=%0d, required %0d 0 0",
                     good1, bad1, q1.size(), exp_good1);
        end
    endtask

    task automatic test_short_preamble;
        send_frame(0, 20, 8, 0, 8'h33);
        exp_bad0++;
        checks++;
        if (bad0 !== 16'(exp_bad0)) begin
            errors++;
            $display("FAIL preamble_20: got bad=%0d, required %0d", bad0, exp_bad0);
        end
        send_frame(0, 27, 8, 0, 8'h33);
        exp_bad0++;
        checks++;
        if (bad0 !== 16'(exp_bad0)) begin
            errors++;
            $display("FAIL preamble_27: got bad=%0d, required %0d", bad0, exp_bad0);
        end
        expect_frame(0, 64, 8'h55, 1'b1, 1'b0);
        send_frame(0, 28, 64, 0, 8'h55);
        exp_good0++;
        checks++;
        if (good0 !== 16'(exp_good0) || bad0 !== 16'(exp_bad0) || q0.size() != 0) begin
            errors++;
            $display("FAIL preamble_28_frame: got good=%0d bad=%0d pending=%0d, required %0d %0d 0",
                     good0, bad0, q0.size(), exp_good0, exp_bad0);
        end
    endtask

    task automatic test_runt;
        expect_frame(0, 60, 8'h80, 1'b1, 1'b1);
        send_frame(0, 28, 60, 0, 8'h80);
        exp_bad0++;
        checks++;
        if (bad0 !== 16'(exp_bad0) || good0 !== 16'(exp_good0) || q0.size() != 0) begin
            errors++;
            $display("FAIL runt_60: got good=%0d bad=%0d pending=%0d, required %0d %0d 0",
                     good0, bad0, q0.size(), exp_good0, exp_bad0);
        end
        expect_frame(0, 64, 8'hC0, 1'b1, 1'b1);
        send_frame(0, 28, 64, 1, 8'hC0);
        exp_bad0++;
        checks++;
        if (bad0 !== 16'(exp_bad0) || good0 !== 16'(exp_good0) || q0.size() != 0) begin
            errors++;
            $display("FAIL odd_dibit: got good=%0d bad=%0d pending=%0d, required %0d %0d 0",
                     good0, bad0, q0.size(), exp_good0, exp_bad0);
        end
    endtask

    task automatic test_oversize;
        expect_frame(0, 1522, 7, 1'b1, 1'b1);
        send_frame(0, 28, 1600, 0, 7);
        exp_bad0++;
        checks++;
        if (bad0 !== 16'(exp_bad0) || good0 !== 16'(exp_good0) || q0.size() != 0) begin
            errors++;
            $display("FAIL oversize_1600: got good=%0d bad=%0d pending=%0d, required %0d %0d 0",
                     good0, bad0, q0.size(), exp_good0, exp_bad0);
        end
        expect_frame(0, 1522, 9, 1'b1, 1'b0);
        send_frame(0, 28, 1522, 0, 9);
        exp_good0++;
        checks++;
        if (good0 !== 16'(exp_good0) || bad0 !== 16'(exp_bad0) || q0.size() != 0) begin
            errors++;
            $display("FAIL max_1522: got good=%0d bad=%0d pending=%0d, required %0d %0d 0",
                     good0, bad0, q0.size(), exp_good0, exp_bad0);
        end
    endtask

    task automatic test_abort;
        exp_t e;
        send_frame(0, 28, 0, 2, 0);
        exp_bad0++;
        checks++;
        if (bad0 !== 16'(exp_bad0) || good0 !== 16'(exp_good0)) begin
            errors++;
            $display("FAIL sfd_then_drop: got good=%0d bad=%0d, required %0d %0d",
                     good0, bad0, exp_good0, exp_bad0);
        end
        for (int i = 0; i < 28; i++) drive(0, 1'b1, 2'b01);
        drive(0, 1'b1, 2'b11);
        for (int i = 0; i < 10; i++) begin
            if (i < 9) begin
                e.d = pat(i, 8'h40); e.last = 1'b0; e.err = 1'b0;
                q0.push_back(e);
            end
            for (int k = 0; k < 4; k++) drive(0, 1'b1, pat(i, 8'h40) >> (2 * k));
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_good0 = 0;
        exp_bad0  = 0;
        checks++;
        if ({axiov0, axiod0, axiolast0, axioerr0, good0, bad0} !== '0 || q0.size() != 0) begin
            errors++;
            $display("FAIL rst_midframe: got v=%b d=%h l=%b e=%b good=%0d bad=%0d pending=%0d, required all 0",
                     axiov0, axiod0, axiolast0, axioerr0, good0, bad0, q0.size());
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(0, 1'b0, 2'b00);
        expect_frame(0, 64, 8'hE0, 1'b1, 1'b0);
        send_frame(0, 28, 64, 0, 8'hE0);
        exp_good0++;
        checks++;
        if (good0 !== 16'(exp_good0) || bad0 !== 16'(exp_bad0) || q0.size() != 0) begin
            errors++;
            $display("FAIL post_rst_frame: got good=%0d bad=%0d pending=%0d, required %0d %0d 0",
                     good0, bad0, q0.size(), exp_good0, exp_bad0);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_preamble();
        test_runt();
        test_oversize();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
